demux1to8_wb: RTL
=================

DEMUX1TO8_WB -- requirements
Module: demux1to8_wb

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, setting the data width of the input and each output lane.
REQ-002 The block SHALL have parameter TIMEOUT, default 15, setting the maximum SEND wait in cycles; it SHALL be used only when DEMUX_TIMEOUT_EN is defined.
REQ-003 Port clk: input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst: input, 1 bit, asynchronous active-high reset.
REQ-005 Port in_data: input, WIDTH bits, write data from the source.
REQ-006 Port in_sel: input, 3 bits, destination lane index 0..7.
REQ-007 Port in_valid: input, 1 bit, the source offers in_data/in_sel.
REQ-008 Port in_ready: output, 1 bit, the block accepts a request this cycle.
REQ-009 Port out_data: output, 8*WIDTH bits, lane k occupies bits [k*WIDTH +: WIDTH].
REQ-010 Port out_valid: output, 8 bits, per-lane delivery strobe.
REQ-011 Port out_ready: input, 8 bits, per-lane destination acceptance.
REQ-012 Port err: output, 1 bit, sticky timeout flag; it SHALL be driven only when DEMUX_TIMEOUT_EN is defined.

Function
REQ-013 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-014 in_ready SHALL be 1 in IDLE and 0 in SEND, decoded from state only.
REQ-015 In IDLE, if in_valid=1 at a rising edge, the block SHALL capture in_data into a hold register and in_sel into a select register, and SHALL enter SEND.
REQ-016 In IDLE, out_valid SHALL be 8'h00.
REQ-017 In SEND, out_valid SHALL be one-hot at bit sel_q and 0 on all other bits.
REQ-018 On the rising edge that enters SEND, lane sel_q of out_data SHALL load the held data.
REQ-019 Lane sel_q of out_data SHALL remain stable throughout SEND.
REQ-020 Lanes not addressed by a request SHALL retain their previous value indefinitely.
REQ-021 In SEND, out_ready[sel_q]=1 at a rising edge SHALL complete the transfer and return the FSM to IDLE.
REQ-022 out_ready bits other than sel_q SHALL be ignored.
REQ-023 Minimum throughput SHALL be one transfer per 2 cycles.
REQ-024 Latency from acceptance to out_valid assertion SHALL be 1 cycle.
REQ-025 A source holding in_valid=1 during SEND SHALL NOT be accepted until the FSM returns to IDLE.
REQ-026 Requests to the same lane back-to-back SHALL overwrite that lane in order, and no request SHALL be lost.
REQ-027 All in_sel values 0..7 SHALL be legal; there SHALL be no out-of-range case.

Reset
REQ-028 Asserting rst SHALL immediately, without waiting for clk, force state to IDLE, out_valid to 0, every out_data lane to 0, the hold register to 0, sel_q to 0, the timeout counter to 0 and err to 0.
REQ-029 A reset asserted during SEND SHALL discard the pending transfer with no partial delivery afterwards.
REQ-030 While rst=1, in_ready SHALL be 1 (IDLE decode), and no capture SHALL occur.
REQ-031 The first capture SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-032 With macro DEMUX_TIMEOUT_EN defined, a counter SHALL clear on SEND entry and increment each SEND cycle without out_ready[sel_q].
REQ-033 With DEMUX_TIMEOUT_EN defined, when the counter equals TIMEOUT-1 without out_ready[sel_q], the FSM SHALL return to IDLE and set err=1 until reset.
REQ-034 With DEMUX_TIMEOUT_EN defined, on a timeout the lane SHALL keep the delivered data.
REQ-035 With DEMUX_TIMEOUT_EN defined, out_ready[sel_q] arriving on the same edge as the timeout SHALL count as a completion, and err SHALL NOT be set.
REQ-036 Without DEMUX_TIMEOUT_EN, SEND SHALL wait indefinitely, no counter SHALL be synthesized, and err SHALL be tied to 0.

Verification
REQ-037 Reset then in_valid=1, in_sel=5, in_data=32'hDEADBEEF, out_ready=8'hFF -> next cycle out_valid=8'h20 and lane5=DEADBEEF; the cycle after, in_ready=1 and all other lanes=0.
REQ-038 Write sel=2 data=0x11 with out_ready[2] held 0 for 4 cycles, and pulse out_ready[3] meanwhile -> out_valid stays 8'h04, in_ready=0, and completion occurs only on the out_ready[2] edge.
REQ-039 Continuous in_valid with sel 0,1,...,7, data=sel*3, out_ready=8'hFF -> each lane k=3k, 8 transfers in 16 cycles.
REQ-040 Assert rst mid-SEND (sel=7, data=0xAA) -> out_valid=0 and lane7=0 within the same cycle, no strobe after release.
REQ-041 With DEMUX_TIMEOUT_EN, sel=1 and out_ready=0 -> return to IDLE after 15 SEND cycles, err=1 persists, and the next transfer proceeds normally.
REQ-042 With DEMUX_TIMEOUT_EN, out_ready[1] asserted exactly on cycle 15 -> completion and err=0.

Source files
------------

// File: rtl/demux1to8_wb.sv
// rtl/demux1to8_wb.sv - 1-to-8 valid/ready demultiplexer with held per-lane data
//
// Purpose:
//   Accepts one request (data + 3-bit lane select) from a single source and
//   delivers it to one of eight destination lanes with a valid/ready
//   handshake. A two-state FSM (IDLE, SEND) allows one outstanding transfer.
//   Each lane's data register keeps the last value written to it until the
//   next request that addresses that lane, or until reset.
//
// Optional feature (macro DEMUX_TIMEOUT_EN):
//   When defined, a SEND that waits TIMEOUT cycles without the addressed
//   lane's out_ready is abandoned: the FSM returns to IDLE, the lane keeps
//   the data it was given, and the sticky err flag is set until reset.
//   When undefined, SEND waits indefinitely, no counter exists and err is 0.
//
// Parameters:
//   WIDTH     - data width of in_data and of each out_data lane
//   TIMEOUT   - SEND wait limit in cycles (only with DEMUX_TIMEOUT_EN)
//
// Ports:
//   clk       - clock, all state updates on the rising edge
//   rst       - asynchronous active-high reset
//   in_data   - source write data
//   in_sel    - destination lane index 0..7
//   in_valid  - source offers in_data/in_sel
//   in_ready  - block accepts a request this cycle (1 in IDLE, 0 in SEND)
//   out_data  - eight lanes, lane k at [k*WIDTH +: WIDTH]
//   out_valid - per-lane delivery strobe, one-hot at sel_q during SEND
//   out_ready - per-lane destination acceptance, only bit sel_q is used
//   err       - sticky timeout flag
module demux1to8_wb #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [2:0]           in_sel,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [8*WIDTH-1:0]   out_data,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
    output logic                 err
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     hold_q, hold_d;
    logic [2:0]           sel_q, sel_d;
    logic [8*WIDTH-1:0]   out_data_q, out_data_d;
    logic [7:0]           out_valid_q, out_valid_d;
    logic                 lane_ready;

`ifdef DEMUX_TIMEOUT_EN
    // Counter only needs to reach TIMEOUT-1.
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 err_q, err_d;
`endif

    // Only the addressed lane's ready is meaningful; the rest are ignored.
    assign lane_ready = out_ready[sel_q];

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        sel_d       = sel_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef DEMUX_TIMEOUT_EN
        cnt_d       = cnt_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    hold_d  = in_data;
                    sel_d   = in_sel;
                    // The lane is written on the same edge that enters
                    // SEND so data is valid together with the strobe.
                    out_data_d[in_sel*WIDTH +: WIDTH] = in_data;
                    out_valid_d = 8'b1 << in_sel;
                    state_d     = SEND;
`ifdef DEMUX_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            SEND: begin
                // A ready on the timeout edge still counts as completion,
                // so it is tested first.
                if (lane_ready) begin
                    out_valid_d = 8'h00;
                    state_d     = IDLE;
                end
`ifdef DEMUX_TIMEOUT_EN
                else if (cnt_q == CNT_LAST) begin
                    out_valid_d = 8'h00;
                    state_d     = IDLE;
                    err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                out_valid_d = 8'h00;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            sel_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= '0;
`ifdef DEMUX_TIMEOUT_EN
            cnt_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            sel_q       <= sel_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef DEMUX_TIMEOUT_EN
            cnt_q       <= cnt_d;
            err_q       <= err_d;
`endif
        end
    end

    // Decoded from state alone so the source sees no combinational path
    // from its own inputs.
    assign in_ready  = (state_q == IDLE);
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef DEMUX_TIMEOUT_EN
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule
